// File: rtl/rvhazard_pkg.sv
// Shared constants, state encoding and helpers for the RISC-V pipeline hazard monitor.
package rvhazard_pkg;

    localparam int NUM_CHK = 7;

    localparam int CHK_X0_WRITE     = 0;
    localparam int CHK_LOAD_USE     = 1;
    localparam int CHK_BRANCH_FLUSH = 2;
    localparam int CHK_STALL_HOLD   = 3;
    localparam int CHK_FWD_A        = 4;
    localparam int CHK_FWD_B        = 5;
    localparam int CHK_STALL_RUN    = 6;

    typedef enum logic [1:0] {
        ST_DISARMED = 2'd0,
        ST_ARMED    = 2'd1,
        ST_TRIPPED  = 2'd2
    } state_e;

    // Index of the lowest set bit, so simultaneous violations report the lowest check.
    function automatic logic [2:0] lowest_set(input logic [NUM_CHK-1:0] v);
        lowest_set = 3'd0;
        for (int i = NUM_CHK - 1; i >= 0; i--) begin
            if (v[i]) lowest_set = 3'(i);
        end
    endfunction

endpackage

// File: rtl/rvhazard_satcnt.sv
// Saturating up-counter with synchronous clear (clear wins) and count enable.
module rvhazard_satcnt #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset_n,
    input  logic         en,
    input  logic         clr,
    output logic [W-1:0] cnt
);

    logic [W-1:0] cnt_q;
    logic [W-1:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en && (cnt_q != '1)) begin
            cnt_d = cnt_q + W'(1);
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign cnt = cnt_q;

endmodule

// File: rtl/rvhazard_monitor.sv
// Watches a 5-stage RISC-V pipeline's hazard unit signals and latches the first rule violation.
module rvhazard_monitor
    import rvhazard_pkg::*;
#(
    parameter int XLEN      = 32,
    parameter int CNT_W     = 32,
    parameter int MAX_STALL = 16
) (
    input  logic               clk,
    input  logic               reset_n,
    input  logic               arm,
    input  logic               clr,
    input  logic [NUM_CHK-1:0] chk_en,
    input  logic               reg_write_w,
    input  logic [4:0]         rd_w,
    input  logic               load_e,
    input  logic [4:0]         rd_e,
    input  logic [31:0]        instr_d,
    input  logic               stall_d,
    input  logic               flush_d,
    input  logic               pc_src_e,
    input  logic [1:0]         forward_ae,
    input  logic [1:0]         forward_be,
    input  logic [XLEN-1:0]    src_a_e,
    input  logic [XLEN-1:0]    src_b_e,
    input  logic [XLEN-1:0]    alu_result_m,
    output logic [1:0]         state,
    output logic [NUM_CHK-1:0] err_sticky,
    output logic [2:0]         fail_id,
    output logic [CNT_W-1:0]   fail_cycle,
    output logic               irq,
    output logic [CNT_W-1:0]   stall_cnt,
    output logic [CNT_W-1:0]   flush_cnt
);

    localparam int RUN_W = $clog2(MAX_STALL + 1) + 1;

    state_e             state_q, state_d;
    logic [NUM_CHK-1:0] sticky_q, sticky_d;
    logic [2:0]         fail_id_q, fail_id_d;
    logic [CNT_W-1:0]   fail_cycle_q, fail_cycle_d;
    logic               irq_q, irq_d;
    logic               stall_q;
    logic [31:0]        instr_q;
    logic [RUN_W-1:0]   run_q, run_d;

    logic [NUM_CHK-1:0] raw;
    logic [NUM_CHK-1:0] viol;
    logic               first_viol;
    logic               active;
    logic [CNT_W-1:0]   cycle_cnt;
    logic [4:0]         rs1_d, rs2_d;

    assign rs1_d  = instr_d[19:15];
    assign rs2_d  = instr_d[24:20];
    assign active = (state_q != ST_DISARMED);

    // Run length saturates at MAX_STALL; reaching it with another stall is the violation.
    always_comb begin
        run_d = '0;
        if (stall_d) begin
            run_d = (run_q >= RUN_W'(MAX_STALL)) ? run_q : run_q + RUN_W'(1);
        end
    end

    always_comb begin
        raw = '0;
        raw[CHK_X0_WRITE]     = reg_write_w && (rd_w == 5'd0);
        raw[CHK_LOAD_USE]     = load_e && (rd_e != 5'd0) &&
                                ((rs1_d == rd_e) || (rs2_d == rd_e)) && !stall_d;
        raw[CHK_BRANCH_FLUSH] = pc_src_e && !flush_d;
        raw[CHK_STALL_HOLD]   = stall_q && !flush_d && (instr_d != instr_q);
        raw[CHK_FWD_A]        = (forward_ae == 2'b10) && (src_a_e != alu_result_m);
        raw[CHK_FWD_B]        = (forward_be == 2'b10) && (src_b_e != alu_result_m);
        raw[CHK_STALL_RUN]    = stall_d && (run_q >= RUN_W'(MAX_STALL));
    end

    // clr suppresses every violation in its cycle so nothing is flagged or captured.
    assign viol       = raw & chk_en & {NUM_CHK{active && !clr}};
    assign first_viol = (state_q == ST_ARMED) && (|viol);

    always_comb begin
        state_d = state_q;
        if (!arm) begin
            state_d = ST_DISARMED;
        end else begin
            case (state_q)
                ST_DISARMED: state_d = ST_ARMED;
                ST_ARMED:    if (first_viol) state_d = ST_TRIPPED;
                ST_TRIPPED:  if (clr) state_d = ST_ARMED;
                default:     state_d = ST_DISARMED;
            endcase
        end
    end

    always_comb begin
        sticky_d     = sticky_q | viol;
        fail_id_d    = fail_id_q;
        fail_cycle_d = fail_cycle_q;
        irq_d        = first_viol;
        if (clr) begin
            sticky_d     = '0;
            fail_id_d    = '0;
            fail_cycle_d = '0;
        end else if (first_viol) begin
            fail_id_d    = lowest_set(viol);
            fail_cycle_d = cycle_cnt;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_DISARMED;
            sticky_q     <= '0;
            fail_id_q    <= '0;
            fail_cycle_q <= '0;
            irq_q        <= 1'b0;
            stall_q      <= 1'b0;
            instr_q      <= '0;
            run_q        <= '0;
        end else begin
            state_q      <= state_d;
            sticky_q     <= sticky_d;
            fail_id_q    <= fail_id_d;
            fail_cycle_q <= fail_cycle_d;
            irq_q        <= irq_d;
            stall_q      <= stall_d;
            instr_q      <= instr_d;
            run_q        <= run_d;
        end
    end

    rvhazard_satcnt #(.W(CNT_W)) u_cycle_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (active),
        .clr     (clr),
        .cnt     (cycle_cnt)
    );

    rvhazard_satcnt #(.W(CNT_W)) u_stall_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (active && stall_d),
        .clr     (clr),
        .cnt     (stall_cnt)
    );

    rvhazard_satcnt #(.W(CNT_W)) u_flush_cnt (
        .clk     (clk),
        .reset_n (reset_n),
        .en      (active && flush_d),
        .clr     (clr),
        .cnt     (flush_cnt)
    );

    assign state      = state_q;
    assign err_sticky = sticky_q;
    assign fail_id    = fail_id_q;
    assign fail_cycle = fail_cycle_q;
    assign irq        = irq_q;

endmodule

// File: tb/tb_rvhazard_monitor.sv
// Self-checking bench for rvhazard_monitor: directed scenarios plus randomized traffic vs a behavioural model.
module tb_rvhazard_monitor;

    localparam int XLEN      = 32;
    localparam int CNT_W     = 5;
    localparam int MAX_STALL = 16;
    localparam int CMAX      = (1 << CNT_W) - 1;
    localparam logic [31:0] IDLE_INSTR = 32'h0000_0033;

    logic             clk = 1'b0;
    logic             reset_n;
    logic             arm;
    logic             clr;
    logic [6:0]       chk_en;
    logic             reg_write_w;
    logic [4:0]       rd_w;
    logic             load_e;
    logic [4:0]       rd_e;
    logic [31:0]      instr_d;
    logic             stall_d;
    logic             flush_d;
    logic             pc_src_e;
    logic [1:0]       forward_ae;
    logic [1:0]       forward_be;
    logic [XLEN-1:0]  src_a_e;
    logic [XLEN-1:0]  src_b_e;
    logic [XLEN-1:0]  alu_result_m;
    logic [1:0]       state;
    logic [6:0]       err_sticky;
    logic [2:0]       fail_id;
    logic [CNT_W-1:0] fail_cycle;
    logic             irq;
    logic [CNT_W-1:0] stall_cnt;
    logic [CNT_W-1:0] flush_cnt;

    int total = 0;
    int bad   = 0;

    // Reference model: 0=disarmed, 1=armed, 2=tripped; counters are plain ints clipped at CMAX.
    int          m_state;
    logic [6:0]  m_sticky;
    int          m_fail_id;
    int          m_fail_cycle;
    int          m_irq;
    int          m_cycle;
    int          m_stallc;
    int          m_flushc;
    int          m_prev_stall;
    logic [31:0] m_prev_instr;
    int          m_run;

    rvhazard_monitor #(.XLEN(XLEN), .CNT_W(CNT_W), .MAX_STALL(MAX_STALL)) dut (
        .clk          (clk),
        .reset_n      (reset_n),
        .arm          (arm),
        .clr          (clr),
        .chk_en       (chk_en),
        .reg_write_w  (reg_write_w),
        .rd_w         (rd_w),
        .load_e       (load_e),
        .rd_e         (rd_e),
        .instr_d      (instr_d),
        .stall_d      (stall_d),
        .flush_d      (flush_d),
        .pc_src_e     (pc_src_e),
        .forward_ae   (forward_ae),
        .forward_be   (forward_be),
        .src_a_e      (src_a_e),
        .src_b_e      (src_b_e),
        .alu_result_m (alu_result_m),
        .state        (state),
        .err_sticky   (err_sticky),
        .fail_id      (fail_id),
        .fail_cycle   (fail_cycle),
        .irq          (irq),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt)
    );

    always #5 clk = ~clk;

    task automatic model_reset();
        m_state = 0; m_sticky = '0; m_fail_id = 0; m_fail_cycle = 0; m_irq = 0;
        m_cycle = 0; m_stallc = 0; m_flushc = 0;
        m_prev_stall = 0; m_prev_instr = '0; m_run = 0;
    endtask

    // Advance the model by one clock using the inputs currently applied.
    task automatic model_step();
        logic [6:0] hit;
        int first;
        int ns;
        int rs1;
        int rs2;
        rs1 = int'(instr_d[19:15]);
        rs2 = int'(instr_d[24:20]);
        hit = '0;
        hit[0] = reg_write_w && (rd_w == 0);
        hit[1] = load_e && (rd_e != 0) && (rs1 == int'(rd_e) || rs2 == int'(rd_e)) && !stall_d;
        hit[2] = pc_src_e && !flush_d;
        hit[3] = (m_prev_stall != 0) && !flush_d && (instr_d != m_prev_instr);
        hit[4] = (forward_ae == 2) && (src_a_e != alu_result_m);
        hit[5] = (forward_be == 2) && (src_b_e != alu_result_m);
        hit[6] = stall_d && (m_run + 1 > MAX_STALL);
        hit = hit & chk_en;
        if (m_state == 0 || clr) hit = '0;
        first = -1;
        for (int i = 0; i < 7; i++) if (hit[i] && first < 0) first = i;

        if (!arm) ns = 0;
        else if (m_state == 0) ns = 1;
        else if (m_state == 1 && first >= 0) ns = 2;
        else if (m_state == 2 && clr) ns = 1;
        else ns = m_state;

        if (clr) begin
            m_sticky = '0; m_fail_id = 0; m_fail_cycle = 0; m_irq = 0;
            m_cycle = 0; m_stallc = 0; m_flushc = 0;
        end else begin
            m_irq = (m_state == 1 && first >= 0) ? 1 : 0;
            if (m_irq != 0) begin
                m_fail_id = first;
                m_fail_cycle = m_cycle;
            end
            m_sticky = m_sticky | hit;
            if (m_state != 0) begin
                if (m_cycle < CMAX) m_cycle++;
                if (stall_d && m_stallc < CMAX) m_stallc++;
                if (flush_d && m_flushc < CMAX) m_flushc++;
            end
        end
        m_state = ns;
        m_prev_stall = stall_d ? 1 : 0;
        m_prev_instr = instr_d;
        m_run = stall_d ? m_run + 1 : 0;
    endtask

    task automatic tick();
        model_step();
        @(posedge clk);
        #1;
    endtask

    task automatic set_idle();
        clr = 1'b0; reg_write_w = 1'b0; rd_w = 5'd1; load_e = 1'b0; rd_e = 5'd0;
        instr_d = IDLE_INSTR; stall_d = 1'b0; flush_d = 1'b0; pc_src_e = 1'b0;
        forward_ae = 2'b00; forward_be = 2'b00;
        src_a_e = '0; src_b_e = '0; alu_result_m = '0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0; arm = 1'b0; chk_en = '0;
        set_idle();
        model_reset();
        #2;
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL reset_state got=%0d exp=0", state); end
        total++; if (err_sticky !== 7'd0) begin bad++; $display("[TB] FAIL reset_sticky got=%b exp=0", err_sticky); end
        total++; if (fail_id !== 3'd0) begin bad++; $display("[TB] FAIL reset_fail_id got=%0d exp=0", fail_id); end
        total++; if (fail_cycle !== '0) begin bad++; $display("[TB] FAIL reset_fail_cycle got=%0d exp=0", fail_cycle); end
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL reset_irq got=%b exp=0", irq); end
        total++; if (stall_cnt !== '0 || flush_cnt !== '0) begin bad++; $display("[TB] FAIL reset_cnt got=%0d/%0d exp=0/0", stall_cnt, flush_cnt); end
        @(posedge clk);
        #1;
        reset_n = 1'b1;
    endtask

    task automatic test_load_use();
        arm = 1'b1; chk_en = 7'h7F;
        set_idle();
        tick();
        tick();
        total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL lu_armed got=%0d exp=1", state); end
        load_e = 1'b1; rd_e = 5'd5;
        instr_d = {7'd0, 5'd0, 5'd5, 3'd0, 5'd0, 7'h33};
        tick();
        total++; if (err_sticky !== 7'b0000010) begin bad++; $display("[TB] FAIL lu_sticky got=%b exp=0000010", err_sticky); end
        total++; if (fail_id !== 3'd1) begin bad++; $display("[TB] FAIL lu_fail_id got=%0d exp=1", fail_id); end
        total++; if (irq !== 1'b1) begin bad++; $display("[TB] FAIL lu_irq got=%b exp=1", irq); end
        total++; if (state !== 2'd2) begin bad++; $display("[TB] FAIL lu_state got=%0d exp=2", state); end
        total++; if (fail_cycle !== CNT_W'(m_fail_cycle)) begin bad++; $display("[TB] FAIL lu_fail_cycle got=%0d exp=%0d", fail_cycle, m_fail_cycle); end
        set_idle();
        tick();
        total++; if (irq !== 1'b0) begin bad++; $display("[TB] FAIL lu_irq_pulse got=%b exp=0", irq); end
        total++; if (err_sticky !== 7'b0000010) begin bad++; $display("[TB] FAIL lu_sticky_hold got=%b exp=0000010", err_sticky); end
    endtask

    task automatic test_stall_run();
        set_idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        total++; if (state !== 2'd1 || err_sticky !== 7'd0) begin bad++; $display("[TB] FAIL sr_clr got=%0d/%b exp=1/0", state, err_sticky); end
        stall_d = 1'b1;
        for (int i = 0; i < MAX_STALL; i++) tick();
        stall_d = 1'b0;
        tick();
        total++; if (err_sticky[6] !== 1'b0) begin bad++; $display("[TB] FAIL sr_16_noflag got=%b exp=0", err_sticky[6]); end
        total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL sr_16_state got=%0d exp=1", state); end
        stall_d = 1'b1;
        for (int i = 0; i < MAX_STALL + 1; i++) tick();
        total++; if (err_sticky[6] !== 1'b1) begin bad++; $display("[TB] FAIL sr_17_flag got=%b exp=1", err_sticky[6]); end
        total++; if (fail_id !== 3'd6) begin bad++; $display("[TB] FAIL sr_fail_id got=%0d exp=6", fail_id); end
        total++; if (stall_cnt !== CNT_W'(CMAX)) begin bad++; $display("[TB] FAIL sr_stall_cnt got=%0d exp=%0d", stall_cnt, CMAX); end
        tick();
        tick();
        total++; if (stall_cnt !== CNT_W'(CMAX)) begin bad++; $display("[TB] FAIL sr_stall_sat got=%0d exp=%0d", stall_cnt, CMAX); end
        total++; if (fail_cycle !== CNT_W'(m_fail_cycle)) begin bad++; $display("[TB] FAIL sr_fail_cycle got=%0d exp=%0d", fail_cycle, m_fail_cycle); end
        set_idle();
        tick();
    endtask

    task automatic test_fwd_mask();
        set_idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        chk_en = 7'h6F;
        forward_ae = 2'b10; src_a_e = 32'h10; alu_result_m = 32'h11;
        tick();
        total++; if (err_sticky !== 7'd0 || state !== 2'd1) begin bad++; $display("[TB] FAIL fwd_masked got=%b/%0d exp=0/1", err_sticky, state); end
        chk_en = 7'h7F;
        tick();
        total++; if (err_sticky !== 7'b0010000) begin bad++; $display("[TB] FAIL fwd_sticky got=%b exp=0010000", err_sticky); end
        total++; if (fail_id !== 3'd4 || irq !== 1'b1) begin bad++; $display("[TB] FAIL fwd_capture got=%0d/%b exp=4/1", fail_id, irq); end
        set_idle();
        tick();
    endtask

    task automatic test_simultaneous();
        set_idle();
        clr = 1'b1;
        tick();
        clr = 1'b0;
        reg_write_w = 1'b1; rd_w = 5'd0; pc_src_e = 1'b1;
        tick();
        total++; if (err_sticky !== 7'b0000101) begin bad++; $display("[TB] FAIL sim_sticky got=%b exp=0000101", err_sticky); end
        total++; if (fail_id !== 3'd0 || irq !== 1'b1) begin bad++; $display("[TB] FAIL sim_capture got=%0d/%b exp=0/1", fail_id, irq); end
        set_idle();
        tick();
        forward_be = 2'b10; src_b_e = 32'h1; alu_result_m = 32'h2;
        tick();
        total++; if (err_sticky !== 7'b0100101) begin bad++; $display("[TB] FAIL sim_later_sticky got=%b exp=0100101", err_sticky); end
        total++; if (fail_id !== 3'd0 || irq !== 1'b0 || state !== 2'd2) begin bad++; $display("[TB] FAIL sim_tripped got=%0d/%b/%0d exp=0/0/2", fail_id, irq, state); end
        total++; if (fail_cycle !== CNT_W'(m_fail_cycle)) begin bad++; $display("[TB] FAIL sim_fail_cycle got=%0d exp=%0d", fail_cycle, m_fail_cycle); end
        set_idle();
    endtask

    task automatic test_clr_collision();
        set_idle();
        clr = 1'b1; reg_write_w = 1'b1; rd_w = 5'd0;
        tick();
        total++; if (err_sticky !== 7'd0 || irq !== 1'b0) begin bad++; $display("[TB] FAIL clr_flags got=%b/%b exp=0/0", err_sticky, irq); end
        total++; if (fail_id !== 3'd0 || fail_cycle !== '0 || stall_cnt !== '0) begin bad++; $display("[TB] FAIL clr_capture got=%0d/%0d/%0d exp=0/0/0", fail_id, fail_cycle, stall_cnt); end
        total++; if (state !== 2'd1) begin bad++; $display("[TB] FAIL clr_state got=%0d exp=1", state); end
        clr = 1'b0;
        tick();
        total++; if (err_sticky !== 7'b0000001 || irq !== 1'b1) begin bad++; $display("[TB] FAIL clr_after got=%b/%b exp=0000001/1", err_sticky, irq); end
        set_idle();
    endtask

    task automatic test_disarm();
        set_idle();
        arm = 1'b0;
        tick();
        total++; if (state !== 2'd0) begin bad++; $display("[TB] FAIL dis_state got=%0d exp=0", state); end
        pc_src_e = 1'b1; flush_d = 1'b0; stall_d = 1'b1;
        tick();
        tick();
        total++; if (err_sticky !== m_sticky || irq !== 1'b0) begin bad++; $display("[TB] FAIL dis_noflag got=%b/%b exp=%b/0", err_sticky, irq, m_sticky); end
        total++; if (stall_cnt !== CNT_W'(m_stallc)) begin bad++; $display("[TB] FAIL dis_stall_cnt got=%0d exp=%0d", stall_cnt, m_stallc); end
        set_idle();
        arm = 1'b1;
        tick();
    endtask

    task automatic test_random();
        for (int cyc = 0; cyc < 600; cyc++) begin
            arm          = ($urandom_range(0, 19) != 0);
            clr          = ($urandom_range(0, 29) == 0);
            chk_en       = 7'($urandom);
            reg_write_w  = ($urandom_range(0, 7) == 0);
            rd_w         = 5'($urandom_range(0, 3));
            load_e       = ($urandom_range(0, 3) == 0);
            rd_e         = 5'($urandom_range(0, 7));
            if ($urandom_range(0, 3) == 0)
                instr_d = {7'd0, 5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)), 15'h0033};
            stall_d      = ($urandom_range(0, 2) != 0);
            flush_d      = ($urandom_range(0, 3) == 0);
            pc_src_e     = ($urandom_range(0, 7) == 0);
            forward_ae   = 2'($urandom);
            forward_be   = 2'($urandom);
            src_a_e      = 32'($urandom_range(0, 3));
            src_b_e      = 32'($urandom_range(0, 3));
            alu_result_m = 32'($urandom_range(0, 3));
            tick();
            total++; if (state !== 2'(m_state)) begin bad++; $display("[TB] FAIL rnd_state cyc=%0d got=%0d exp=%0d", cyc, state, m_state); end
            total++; if (err_sticky !== m_sticky) begin bad++; $display("[TB] FAIL rnd_sticky cyc=%0d got=%b exp=%b", cyc, err_sticky, m_sticky); end
            total++; if (fail_id !== 3'(m_fail_id)) begin bad++; $display("[TB] FAIL rnd_fail_id cyc=%0d got=%0d exp=%0d", cyc, fail_id, m_fail_id); end
            total++; if (fail_cycle !== CNT_W'(m_fail_cycle)) begin bad++; $display("[TB] FAIL rnd_fail_cycle cyc=%0d got=%0d exp=%0d", cyc, fail_cycle, m_fail_cycle); end
            total++; if (irq !== 1'(m_irq)) begin bad++; $display("[TB] FAIL rnd_irq cyc=%0d got=%b exp=%0d", cyc, irq, m_irq); end
            total++; if (stall_cnt !== CNT_W'(m_stallc)) begin bad++; $display("[TB] FAIL rnd_stall_cnt cyc=%0d got=%0d exp=%0d", cyc, stall_cnt, m_stallc); end
            total++; if (flush_cnt !== CNT_W'(m_flushc)) begin bad++; $display("[TB] FAIL rnd_flush_cnt cyc=%0d got=%0d exp=%0d", cyc, flush_cnt, m_flushc); end
        end
        set_idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_stall_run();
        test_fwd_mask();
        test_simultaneous();
        test_clr_collision();
        test_disarm();
        test_random();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
